// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receive front end: frame geometry and word-select encoding.
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int BCNT_BITS  = $clog2(FRAME_BITS);

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divides HCLK down to i2s_clk and flags the HCLK cycle on which
// i2s_clk is about to rise or fall, so the top can act on the same edge as the toggle.
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic en,
  output logic i2s_clk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = en && (cnt == CNT_MAX);
  assign rise = wrap && !i2s_clk;
  assign fall = wrap && i2s_clk;

  // Disabling parks the clock low with the divider cleared, so re-enabling restarts cleanly.
  always_ff @(posedge HCLK) begin
    if (HRESET || !en) begin
      cnt     <= '0;
      i2s_clk <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      i2s_clk <= !i2s_clk;
    end else begin
      cnt     <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2s_rx_frontend.sv
// I2S master receive front end: drives i2s_clk/ws, deserialises rx into 64-bit stereo frames
// and hands them to the consumer through a one-entry holding register with a sticky overrun flag.
module i2s_rx_frontend
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  en,
  input  logic                  rx,
  output logic                  i2s_clk,
  output logic                  ws,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun,
  input  logic                  ovr_clr
);

  logic                  rise;
  logic                  fall;
  logic [BCNT_BITS-1:0]  bcnt;
  logic [BCNT_BITS-1:0]  bcnt_next;
  logic                  primed;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_word;
  logic                  complete;
  logic                  drain;
  logic                  load;
  logic                  drop;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .en      (en),
    .i2s_clk (i2s_clk),
    .rise    (rise),
    .fall    (fall)
  );

  assign bcnt_next  = bcnt + BCNT_BITS'(1);
  assign frame_word = {shreg[FRAME_BITS-2:0], rx};

  // The rise at bcnt==0 carries the right-slot LSB; it closes a frame only once a left MSB was seen.
  assign complete = rise && primed && (bcnt == '0);
  assign drain    = frame_valid && frame_ready;
  assign load     = complete && (!frame_valid || drain);
  assign drop     = complete && frame_valid && !frame_ready;

  always_ff @(posedge HCLK) begin
    if (HRESET || !en) begin
      bcnt   <= '0;
      ws     <= WS_LEFT;
      primed <= 1'b0;
    end else begin
      if (fall) begin
        bcnt <= bcnt_next;
        ws   <= (bcnt_next >= BCNT_BITS'(SLOT_BITS)) ? WS_RIGHT : WS_LEFT;
      end
      if (rise && (bcnt == BCNT_BITS'(1))) begin
        primed <= 1'b1;
      end
    end
  end

  // The shift register is left untouched while disabled; priming makes its stale contents harmless.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      shreg <= '0;
    end else if (rise) begin
      shreg <= frame_word;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load) begin
        frame_data  <= frame_word;
        frame_valid <= 1'b1;
      end else if (drain) begin
        frame_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Directed bench for i2s_rx_frontend: a CLK_DIV=2 instance for framing, handshake, overrun and
// enable behaviour, plus a CLK_DIV=5 instance for the slower bit clock.
module tb_i2s_rx_frontend;

  localparam logic [63:0] F1 = 64'hA5A5_0001_1234_8000;
  localparam logic [63:0] W2 = 64'h0F0F_F0F0_3C3C_C3C3;
  localparam logic [63:0] W3 = 64'h5555_AAAA_0000_1111;
  localparam logic [63:0] W4 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] W5 = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] FB = 64'hFFFF_0000_0000_FFFF;

  logic        HCLK = 1'b0;
  logic        HRESET;

  logic        en_a, rx_a, sck_a, ws_a, fv_a, ready_a, ovr_a, ovr_clr_a;
  logic [63:0] data_a;
  logic        en_b, rx_b, sck_b, ws_b, fv_b, ready_b, ovr_b, ovr_clr_b;
  logic [63:0] data_b;

  logic [63:0] word_a = F1;
  logic [63:0] word_b = FB;
  int          falls_a = 0;
  int          falls_b = 0;
  int          rises_a = 0;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = !HCLK;

  i2s_rx_frontend #(.CLK_DIV(2)) dut_a (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .en          (en_a),
    .rx          (rx_a),
    .i2s_clk     (sck_a),
    .ws          (ws_a),
    .frame_data  (data_a),
    .frame_valid (fv_a),
    .frame_ready (ready_a),
    .overrun     (ovr_a),
    .ovr_clr     (ovr_clr_a)
  );

  i2s_rx_frontend #(.CLK_DIV(5)) dut_b (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .en          (en_b),
    .rx          (rx_b),
    .i2s_clk     (sck_b),
    .ws          (ws_b),
    .frame_data  (data_b),
    .frame_valid (fv_b),
    .frame_ready (ready_b),
    .overrun     (ovr_b),
    .ovr_clr     (ovr_clr_b)
  );

  // Codec model: after the k-th falling SCK edge since enable, present frame bit (64-k) mod 64.
  always @(negedge sck_a or negedge en_a) begin
    if (!en_a || HRESET) begin
      falls_a = 0;
    end else begin
      falls_a = falls_a + 1;
      rx_a    = word_a[(64 - (falls_a % 64)) % 64];
    end
  end

  always @(negedge sck_b or negedge en_b) begin
    if (!en_b || HRESET) begin
      falls_b = 0;
    end else begin
      falls_b = falls_b + 1;
      rx_b    = word_b[(64 - (falls_b % 64)) % 64];
    end
  end

  always @(posedge sck_a or negedge en_a) begin
    if (!en_a) rises_a = 0;
    else if (!HRESET) rises_a = rises_a + 1;
  end

  task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic wait_fv_a(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge HCLK);
      if (fv_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n;

    HRESET    = 1'b1;
    en_a      = 1'b1;
    ready_a   = 1'b1;
    ovr_clr_a = 1'b0;
    rx_a      = 1'b0;
    en_b      = 1'b0;
    ready_b   = 1'b1;
    ovr_clr_b = 1'b0;
    rx_b      = 1'b0;

    // Reset values and first SCK toggle
    step(3);
    check_bit("rst_sck", sck_a, 1'b0);
    check_bit("rst_ws", ws_a, 1'b0);
    check_bit("rst_fv", fv_a, 1'b0);
    check_bit("rst_ovr", ovr_a, 1'b0);
    check_word("rst_data", data_a, 64'h0);
    HRESET = 1'b0;
    step(1);
    check_bit("sck_low_1_after_rst", sck_a, 1'b0);
    step(1);
    check_bit("sck_high_2_after_rst", sck_a, 1'b1);

    // First frame arrives with the 65th rise
    wait_fv_a(400, ok);
    check_bit("first_frame_seen", ok, 1'b1);
    check_int("first_frame_rises", rises_a, 65);
    check_word("first_frame_data", data_a, F1);
    check_bit("first_frame_ws", ws_a, 1'b0);
    step(1);
    check_bit("first_frame_drained", fv_a, 1'b0);

    // ws is low and high for 32 SCK periods each (128 HCLK)
    n = 0;
    while (!ws_a && n < 300) begin step(1); n++; end
    n = 0;
    while (ws_a && n < 300) begin step(1); n++; end
    check_int("ws_high_cycles", n, 128);
    n = 0;
    while (!ws_a && n < 300) begin step(1); n++; end
    check_int("ws_low_cycles", n, 128);

    // Holding register and overrun
    wait_fv_a(400, ok);
    check_bit("repeat_frame_seen", ok, 1'b1);
    check_word("repeat_frame_data", data_a, F1);
    word_a = W2;
    step(1);
    ready_a = 1'b0;
    wait_fv_a(400, ok);
    check_bit("w2_seen", ok, 1'b1);
    check_word("w2_data", data_a, W2);
    check_bit("w2_no_ovr", ovr_a, 1'b0);
    word_a = W3;
    step(256);
    check_bit("ovr_set", ovr_a, 1'b1);
    check_bit("ovr_fv_held", fv_a, 1'b1);
    check_word("ovr_data_held", data_a, W2);
    ovr_clr_a = 1'b1;
    step(1);
    check_bit("ovr_cleared", ovr_a, 1'b0);
    ovr_clr_a = 1'b0;
    step(254);
    ovr_clr_a = 1'b1;
    step(1);
    check_bit("ovr_set_wins", ovr_a, 1'b1);
    check_word("ovr_data_held2", data_a, W2);
    word_a = W4;
    step(1);
    check_bit("ovr_cleared2", ovr_a, 1'b0);
    ovr_clr_a = 1'b0;

    // Drain and reload in the same cycle
    step(254);
    check_bit("fv_before_reload", fv_a, 1'b1);
    ready_a = 1'b1;
    step(1);
    check_bit("fv_after_reload", fv_a, 1'b1);
    check_word("reload_data", data_a, W4);
    check_bit("reload_no_ovr", ovr_a, 1'b0);
    ready_a = 1'b0;
    step(1);
    check_bit("fv_still_held", fv_a, 1'b1);
    ready_a = 1'b1;
    step(1);
    check_bit("fv_final_drain", fv_a, 1'b0);

    // Disable mid-frame at bcnt==20, then re-enable
    step(78);
    check_bit("sck_high_at_bcnt20", sck_a, 1'b1);
    en_a = 1'b0;
    step(1);
    check_bit("sck_parked", sck_a, 1'b0);
    check_bit("ws_parked", ws_a, 1'b0);
    step(10);
    check_bit("sck_still_parked", sck_a, 1'b0);
    check_bit("no_partial_frame", fv_a, 1'b0);
    en_a   = 1'b1;
    word_a = W5;
    wait_fv_a(400, ok);
    check_bit("reenable_frame_seen", ok, 1'b1);
    check_int("reenable_rises", rises_a, 65);
    check_word("reenable_data", data_a, W5);

    // CLK_DIV=5 instance
    en_b = 1'b1;
    n = 0;
    while (!sck_b && n < 20) begin step(1); n++; end
    n = 0;
    while (sck_b && n < 20) begin step(1); n++; end
    check_int("div5_high_cycles", n, 5);
    n = 0;
    while (!sck_b && n < 20) begin step(1); n++; end
    check_int("div5_low_cycles", n, 5);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (fv_b) begin
        ok = 1'b1;
        break;
      end
    end
    check_bit("div5_frame_seen", ok, 1'b1);
    check_word("div5_data", data_b, FB);
    check_bit("div5_ws", ws_b, 1'b0);
    check_bit("div5_no_ovr", ovr_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
